// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath control FSM with MUL stall and illegal-op trap
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUOp,
    output logic       shl_sel,
    output logic       shr_sel,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SPEC2 = 6'b011100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_MUL   = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_ROT = 4'b1010;
    localparam logic [3:0] ALU_CLO = 4'b1011;
    localparam logic [3:0] ALU_CLZ = 4'b1100;

    stateT      curState;
    logic [5:0] opLatched;
    logic [5:0] funcLatched;
    logic [1:0] mulCount;
    logic       illegalFlag;

    function automatic logic isSupported(input logic [5:0] opIn, input logic [5:0] fnIn);
        case (opIn)
            OP_RTYPE: isSupported = fnIn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                                 6'b101010, 6'b000000, 6'b000010};
            OP_SPEC2: isSupported = fnIn inside {6'b100001, 6'b100000, 6'b000010, 6'b000110};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: isSupported = 1'b1;
            default: isSupported = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            curState    <= FETCH;
            mulCount    <= 2'd0;
            illegalFlag <= 1'b0;
            opLatched   <= 6'd0;
            funcLatched <= 6'd0;
        end else begin
            case (curState)
                FETCH: if (mem_ready) curState <= DECODE;
                DECODE: begin
                    // The IR was written at the end of FETCH, so Op/func are valid here.
                    opLatched   <= Op;
                    funcLatched <= func;
                    if (Op == OP_J) begin
                        curState <= FETCH;
                    end else if (isSupported(Op, func)) begin
                        curState <= EXEC;
                        mulCount <= (Op == OP_SPEC2 && func == FN_MUL) ? 2'd3 : 2'd0;
                    end else begin
                        curState    <= TRAP;
                        illegalFlag <= 1'b1;
                    end
                end
                EXEC: begin
                    if (opLatched == OP_LW || opLatched == OP_SW) curState <= MEM;
                    else if (opLatched == OP_BEQ)                 curState <= FETCH;
                    else if (mulCount != 2'd0)                    mulCount <= mulCount - 2'd1;
                    else                                          curState <= WB;
                end
                MEM:     if (mem_ready) curState <= (opLatched == OP_LW) ? WB : FETCH;
                WB:      curState <= FETCH;
                TRAP:    curState <= TRAP;
                default: curState <= FETCH;
            endcase
        end
    end

    assign state = curState;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALUOp       = ALU_ADD;
        shl_sel     = 1'b0;
        shr_sel     = 1'b0;
        illegal     = 1'b0;
        if (rst_n) begin
            illegal = illegalFlag;
            case (curState)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    if (Op == OP_J) begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b10;
                    end
                end
                EXEC: begin
                    case (opLatched)
                        OP_RTYPE: begin
                            ALUSrcA = 1'b1;
                            case (funcLatched)
                                6'b100010: ALUOp = ALU_SUB;
                                6'b100100: ALUOp = ALU_AND;
                                6'b100101: ALUOp = ALU_OR;
                                6'b101010: ALUOp = ALU_SLT;
                                6'b000000: begin ALUOp = ALU_SLL; shl_sel = 1'b1; shr_sel = 1'b1; end
                                6'b000010: begin ALUOp = ALU_SRL; shl_sel = 1'b1; shr_sel = 1'b1; end
                                default:   ALUOp = ALU_ADD;
                            endcase
                        end
                        OP_SPEC2: begin
                            ALUSrcA = 1'b1;
                            case (funcLatched)
                                6'b100001: ALUOp = ALU_CLO;
                                6'b100000: ALUOp = ALU_CLZ;
                                6'b000010: ALUOp = ALU_MUL;
                                6'b000110: ALUOp = ALU_ROT;
                                default:   ALUOp = ALU_ADD;
                            endcase
                        end
                        OP_ADDI, OP_LW, OP_SW: begin
                            ALUSrcA = 1'b1;
                            ALUSrcB = 2'b10;
                        end
                        OP_BEQ: begin
                            ALUSrcA     = 1'b1;
                            ALUOp       = ALU_SUB;
                            PCWriteCond = 1'b1;
                            PCSrc       = 2'b01;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (opLatched == OP_LW);
                    MemWrite = (opLatched == OP_SW);
                end
                WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (opLatched == OP_RTYPE || opLatched == OP_SPEC2);
                    MemtoReg = (opLatched == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] func;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, shl_sel, shr_sel, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUOp;
    logic [2:0] state;
    logic [20:0] ctl;

    int nCompared   = 0;
    int nMismatched = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .func(func), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUOp(ALUOp), .shl_sel(shl_sel), .shr_sel(shr_sel), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign ctl = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, shl_sel, shr_sel, illegal};

    localparam logic [20:0] PCW   = 21'd1 << 20;
    localparam logic [20:0] PCWC  = 21'd1 << 19;
    localparam logic [20:0] IORD  = 21'd1 << 18;
    localparam logic [20:0] IRW   = 21'd1 << 17;
    localparam logic [20:0] MRD   = 21'd1 << 16;
    localparam logic [20:0] MWR   = 21'd1 << 15;
    localparam logic [20:0] M2R   = 21'd1 << 14;
    localparam logic [20:0] RD    = 21'd1 << 13;
    localparam logic [20:0] RW    = 21'd1 << 12;
    localparam logic [20:0] ASA   = 21'd1 << 11;
    localparam logic [20:0] SB4   = 21'd1 << 9;
    localparam logic [20:0] SBIMM = 21'd2 << 9;
    localparam logic [20:0] SBSH  = 21'd3 << 9;
    localparam logic [20:0] PCSBR = 21'd1 << 7;
    localparam logic [20:0] PCSJ  = 21'd2 << 7;
    localparam logic [20:0] A_SUB = 21'd1 << 3;
    localparam logic [20:0] A_MUL = 21'd2 << 3;
    localparam logic [20:0] A_AND = 21'd3 << 3;
    localparam logic [20:0] A_OR  = 21'd4 << 3;
    localparam logic [20:0] A_SLT = 21'd5 << 3;
    localparam logic [20:0] A_SLL = 21'd8 << 3;
    localparam logic [20:0] A_SRL = 21'd9 << 3;
    localparam logic [20:0] A_ROT = 21'd10 << 3;
    localparam logic [20:0] A_CLO = 21'd11 << 3;
    localparam logic [20:0] A_CLZ = 21'd12 << 3;
    localparam logic [20:0] SHL   = 21'd1 << 2;
    localparam logic [20:0] SHR   = 21'd1 << 1;
    localparam logic [20:0] ILL   = 21'd1;
    localparam logic [20:0] FW    = MRD | SB4;
    localparam logic [20:0] FG    = FW | IRW | PCW;
    localparam logic [20:0] DEC   = SBSH;

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; Op = 6'b000000; func = 6'b100000;
        @(posedge clk);
        @(negedge clk);
        nCompared++;
        if (state !== 3'd0 || ctl !== 21'd0) begin
            nMismatched++;
            $display("FAIL reset: got state=%0d ctl=%h, want state=0 ctl=000000", state, ctl);
        end
    endtask

    task automatic test_add();
        bit          mr [5] = '{1, 1, 1, 1, 0};
        logic [23:0] ex [5] = '{{3'd0, FG}, {3'd1, DEC}, {3'd2, ASA}, {3'd4, RW | RD}, {3'd0, FW}};
        rst_n = 1'b1; Op = 6'b000000; func = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            // Scramble the inputs once DECODE is over: the latched instruction must still win.
            if (i == 2) begin Op = 6'b101011; func = 6'b000010; end
            mem_ready = mr[i];
            #1;
            nCompared++;
            if ({state, ctl} !== ex[i]) begin
                nMismatched++;
                $display("FAIL add[%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         i, state, ctl, ex[i][23:21], ex[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fetch_wait();
        bit          mr [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        logic [23:0] ex [8] = '{{3'd0, FW}, {3'd0, FW}, {3'd0, FW}, {3'd0, FG}, {3'd1, DEC},
                                {3'd2, ASA | A_SUB}, {3'd4, RW | RD}, {3'd0, FW}};
        Op = 6'b000000; func = 6'b100010;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            nCompared++;
            if ({state, ctl} !== ex[i]) begin
                nMismatched++;
                $display("FAIL fetch_wait[%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         i, state, ctl, ex[i][23:21], ex[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0]  opT [9] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                 6'b011100, 6'b011100, 6'b011100, 6'b001000};
        logic [5:0]  fnT [9] = '{6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010,
                                 6'b100001, 6'b100000, 6'b000110, 6'b010101};
        logic [20:0] exT [9] = '{ASA | A_AND, ASA | A_OR, ASA | A_SLT, ASA | A_SLL | SHL | SHR,
                                 ASA | A_SRL | SHL | SHR, ASA | A_CLO, ASA | A_CLZ, ASA | A_ROT,
                                 ASA | SBIMM};
        logic [20:0] wbT [9] = '{RW | RD, RW | RD, RW | RD, RW | RD, RW | RD, RW | RD, RW | RD,
                                 RW | RD, RW};
        logic [23:0] seq [4];
        mem_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            Op = opT[j]; func = fnT[j];
            seq = '{{3'd0, FG}, {3'd1, DEC}, {3'd2, exT[j]}, {3'd4, wbT[j]}};
            for (int k = 0; k < 4; k++) begin
                #1;
                nCompared++;
                if ({state, ctl} !== seq[k]) begin
                    nMismatched++;
                    $display("FAIL alu_ops[%0d.%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                             j, k, state, ctl, seq[k][23:21], seq[k][20:0]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_mul();
        bit          rs [21] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        bit          mr [21] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [23:0] ex [21] = '{{3'd0, FG}, {3'd1, DEC}, {3'd2, ASA | A_MUL}, {3'd2, ASA | A_MUL},
                                 {3'd2, ASA | A_MUL}, {3'd2, ASA | A_MUL}, {3'd4, RW | RD},
                                 {3'd0, FW}, {3'd0, FG}, {3'd1, DEC}, {3'd2, ASA | A_MUL},
                                 {3'd2, 21'd0}, {3'd0, 21'd0}, {3'd0, FG}, {3'd1, DEC},
                                 {3'd2, ASA | A_MUL}, {3'd2, ASA | A_MUL}, {3'd2, ASA | A_MUL},
                                 {3'd2, ASA | A_MUL}, {3'd4, RW | RD}, {3'd0, FW}};
        Op = 6'b011100; func = 6'b000010;
        for (int i = 0; i < 21; i++) begin
            rst_n = rs[i]; mem_ready = mr[i];
            #1;
            nCompared++;
            if ({state, ctl} !== ex[i]) begin
                nMismatched++;
                $display("FAIL mul[%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         i, state, ctl, ex[i][23:21], ex[i][20:0]);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw_sw();
        bit          mr [15] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
        logic [23:0] ex [15] = '{{3'd0, FG}, {3'd1, DEC}, {3'd2, ASA | SBIMM}, {3'd3, IORD | MRD},
                                 {3'd3, IORD | MRD}, {3'd3, IORD | MRD}, {3'd4, RW | M2R},
                                 {3'd0, FW}, {3'd0, FG}, {3'd1, DEC}, {3'd2, ASA | SBIMM},
                                 {3'd3, IORD | MWR}, {3'd3, IORD | MWR}, {3'd3, IORD | MWR},
                                 {3'd0, FW}};
        Op = 6'b100011; func = 6'b000000;
        for (int i = 0; i < 15; i++) begin
            if (i == 8) Op = 6'b101011;
            mem_ready = mr[i];
            #1;
            nCompared++;
            if ({state, ctl} !== ex[i]) begin
                nMismatched++;
                $display("FAIL lw_sw[%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         i, state, ctl, ex[i][23:21], ex[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump();
        bit          mr [7] = '{1, 1, 1, 0, 1, 1, 0};
        logic [23:0] ex [7] = '{{3'd0, FG}, {3'd1, DEC}, {3'd2, ASA | A_SUB | PCWC | PCSBR},
                                {3'd0, FW}, {3'd0, FG}, {3'd1, DEC | PCW | PCSJ}, {3'd0, FW}};
        Op = 6'b000100; func = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) Op = 6'b000010;
            mem_ready = mr[i];
            #1;
            nCompared++;
            if ({state, ctl} !== ex[i]) begin
                nMismatched++;
                $display("FAIL branch_jump[%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         i, state, ctl, ex[i][23:21], ex[i][20:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        bit          rs [21];
        bit          mr [21];
        logic [23:0] ex [21];
        for (int i = 0; i < 21; i++) begin
            rs[i] = 1'b1; mr[i] = 1'b1; ex[i] = {3'd5, ILL};
        end
        // Cycles 2..11 sit in TRAP while mem_ready toggles.
        for (int i = 2; i < 12; i++) mr[i] = i[0];
        ex[0]  = {3'd0, FG};  ex[1]  = {3'd1, DEC};
        rs[12] = 1'b0;        ex[12] = {3'd5, 21'd0};
        rs[13] = 1'b0;        ex[13] = {3'd0, 21'd0};
        mr[14] = 1'b0;        ex[14] = {3'd0, FW};
        ex[15] = {3'd0, FG};  ex[16] = {3'd1, DEC};  ex[17] = {3'd5, ILL};
        rs[18] = 1'b0;        ex[18] = {3'd5, 21'd0};
        rs[19] = 1'b0;        ex[19] = {3'd0, 21'd0};
        mr[20] = 1'b0;        ex[20] = {3'd0, FW};
        Op = 6'b111111; func = 6'b100000;
        for (int i = 0; i < 21; i++) begin
            if (i == 15) begin Op = 6'b000000; func = 6'b000011; end
            rst_n = rs[i]; mem_ready = mr[i];
            #1;
            nCompared++;
            if ({state, ctl} !== ex[i]) begin
                nMismatched++;
                $display("FAIL trap[%0d]: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         i, state, ctl, ex[i][23:21], ex[i][20:0]);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_fetch_wait();
        test_alu_ops();
        test_mul();
        test_lw_sw();
        test_branch_jump();
        test_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- Op  in  6  opcode field from the instruction register.
- func  in  6  function field from the instruction register.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite, PCWriteCond, IorD, IRWrite  out  1 each  PC/IR/address-mux strobes.
- MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
- PCSrc  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target.
- ALUOp  out  4  ALU op: ADD 0000, SUB 0001, MUL 0010, AND 0011, OR 0100, SLT 0101, SLL 1000, SRL 1001, ROT 1010, CLO 1011, CLZ 1100.
- shl_sel, shr_sel  out  1 each  shifter path select.
- state  out  3  current FSM state (debug).
- illegal  out  1  sticky undefined-instruction flag.
REQ-002 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Function
REQ-003 Outputs SHALL be Moore (state and latched op/func only); unlisted outputs SHALL be 0 in each state.
REQ-004 In DECODE, the block SHALL latch Op and func into internal registers, which SHALL drive all later decisions for the instruction.
REQ-005 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01 and ALUOp=ADD.
REQ-006 In FETCH, if mem_ready=1 the block SHALL also drive IRWrite=1, PCWrite=1 and PCSrc=00, then go to DECODE; otherwise it SHALL hold FETCH with IRWrite=PCWrite=0.
REQ-007 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=ADD.
REQ-008 DECODE transitions: Op=000010 (J) SHALL drive PCWrite=1, PCSrc=10 and go to FETCH; supported instructions SHALL go to EXEC; anything else SHALL go to TRAP.
REQ-009 Supported instructions: Op=000000 with func in {100000, 100010, 100100, 100101, 101010, 000000, 000010}; Op=011100 with func in {100001, 100000, 000010, 000110}; Op in {001000 ADDI, 100011 LW, 101011 SW, 000100 BEQ}.
REQ-010 EXEC for R-type (Op=000000) SHALL drive ALUSrcA=1 and ALUSrcB=00, with ALUOp by func: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT, 000000->SLL, 000010->SRL.
REQ-011 SLL and SRL SHALL additionally drive shl_sel=shr_sel=1.
REQ-012 EXEC for Op=011100 SHALL drive ALUSrcA=1 and ALUSrcB=00, with ALUOp by func: 100001->CLO, 100000->CLZ, 000010->MUL, 000110->ROT.
REQ-013 MUL SHALL hold EXEC for exactly 4 cycles using a 2-bit counter loaded with 3 on entry and decremented each cycle; the block SHALL leave EXEC to WB when the counter is 0.
REQ-014 All other R-type and 011100 instructions SHALL spend 1 cycle in EXEC, then go to WB.
REQ-015 EXEC for ADDI, LW and SW SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=ADD; ADDI SHALL then go to WB, and LW and SW SHALL go to MEM.
REQ-016 EXEC for BEQ SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1 and PCSrc=01, then go to FETCH.
REQ-017 MEM SHALL drive IorD=1, plus MemRead=1 for LW or MemWrite=1 for SW.
REQ-018 MEM SHALL hold until mem_ready=1; LW SHALL then go to WB and SW to FETCH.
REQ-019 WB SHALL drive RegWrite=1, with RegDst=1 for Op 000000/011100 (0 otherwise) and MemtoReg=1 only for LW, then go to FETCH.
REQ-020 TRAP SHALL drive illegal=1 with all write and memory strobes 0, and SHALL be left only by reset.
REQ-021 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-022 Changes to Op or func after DECODE SHALL have no effect until the next DECODE.

Reset
REQ-023 On a rising clk edge with rst_n=0, the block SHALL set state=FETCH, the counter to 0, illegal=0 and clear the latched op/func, in any state including mid-MUL, mid-MEM and TRAP.
REQ-024 While rst_n=0, every output except state SHALL be forced to 0.
REQ-025 The block SHALL resume FETCH behaviour on the first edge after rst_n=1.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then release with mem_ready=1 and Op/func=000000/100000 (ADD) -> states 0,1,2,4,0; ALUOp=0000 in EXEC; RegWrite=1 and RegDst=1 in WB.
- FETCH with mem_ready=0 for 3 cycles, then 1 -> IRWrite and PCWrite=0 for 3 cycles, 1 on the 4th cycle, DECODE next.
- Op/func=011100/000010 (MUL) -> exactly 4 EXEC cycles with ALUOp=0010, then WB; rst_n=0 on the 2nd EXEC cycle -> state=0, all outputs 0.
- LW, then SW, each with mem_ready delayed 2 cycles in MEM -> LW path 0,1,2,3,3,3,4 with MemtoReg=1 in WB; SW path 0,1,2,3,3,3,0 with MemWrite=1 throughout MEM.
- BEQ -> EXEC drives ALUOp=0001, PCWriteCond=1, PCSrc=01, then FETCH; J -> DECODE drives PCWrite=1, PCSrc=10, then FETCH.
- Op=111111 -> TRAP with illegal=1 held for 10 cycles regardless of mem_ready; rst_n=0 -> illegal=0, state=0.
